reg_file_reader: RTL

//  Read-side sequencer for the 8x32 register file: on start, walks a run of

---
 rtl/reg_file_reader.sv | 110 +++++++++++
 1 files changed

// File: rtl/reg_file_reader.sv
// Read-side sequencer for a small register file: walks a run of consecutive
// addresses on the file's read port and streams each word out over valid/ready.
module reg_file_reader #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] rf_rAddr,
  input  logic [DATA_W-1:0] rf_rData,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   MAX_COUNT = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [ADDR_W:0]   REM_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_t          state;
  state_t          state_next;
  logic [ADDR_W:0] remaining;

  // Handshake: a word transfers on any rising edge where out_valid && out_ready.
  // out_valid is only ever high in HOLD, so a transfer is "HOLD && out_ready";
  // out_data/out_last/rf_rAddr stay frozen until that transfer happens.
  logic xfer;
  assign xfer = (state == HOLD) && out_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (count == '0) ? DONE : FETCH;
        end
      end
      FETCH: state_next = HOLD;
      HOLD: begin
        if (xfer) begin
          state_next = (remaining == REM_ONE) ? DONE : FETCH;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rf_rAddr  <= '0;
      remaining <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rf_rAddr  <= first_addr;
            remaining <= (count > MAX_COUNT) ? MAX_COUNT : count;
          end
        end
        FETCH: begin
          out_data  <= rf_rData;
          out_valid <= 1'b1;
          out_last  <= (remaining == REM_ONE);
        end
        HOLD: begin
          if (xfer) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            remaining <= remaining - REM_ONE;
            // Address wraps naturally because NUM_REGS == 2**ADDR_W.
            if (remaining != REM_ONE) begin
              rf_rAddr <= rf_rAddr + ADDR_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
